// File: rtl/bcedn_out_pkg.sv
// Shared types and width helpers for the binary decoder argmax output stage.
package bcedn_out_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Decoder score width: conv output plus normalisation reference scale.
  localparam int unsigned CONV_OUT_WIDTH      = 22;
  localparam int unsigned NORMREF_SCALE_WIDTH = 8;
  localparam int unsigned DEF_SCORE_WIDTH     = CONV_OUT_WIDTH + NORMREF_SCALE_WIDTH;

  localparam int unsigned DEF_N_CLASS = 38;
  localparam int unsigned DEF_H_OUT   = 32;
  localparam int unsigned DEF_W_OUT   = 128;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CLS_W = clog2_min1(DEF_N_CLASS);
  localparam int unsigned ROW_W = clog2_min1(DEF_H_OUT);
  localparam int unsigned COL_W = clog2_min1(DEF_W_OUT);

endpackage

// File: rtl/argmax_acc.sv
// Running argmax over one pixel's class scores; exposes the post-update best values.
module argmax_acc
  import bcedn_out_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int unsigned IDX_W       = CLS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   first,
  input  logic                   valid,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic [IDX_W-1:0]       idx,
  output logic [SCORE_WIDTH-1:0] best_score_c,
  output logic [IDX_W-1:0]       best_idx_c
);

  logic [SCORE_WIDTH-1:0] best_score;
  logic [IDX_W-1:0]       best_idx;
  logic                   take_c;

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    take_c       = valid && (first || ($signed(score) > $signed(best_score)));
    best_score_c = take_c ? score : best_score;
    best_idx_c   = take_c ? idx   : best_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      best_score <= '0;
      best_idx   <= '0;
    end else begin
      best_score <= best_score_c;
      best_idx   <= best_idx_c;
    end
  end

endmodule

// File: rtl/bcedn_argmax_out.sv
// Per-pixel argmax classifier with raster tracking and frame control.
module bcedn_argmax_out
  import bcedn_out_pkg::*;
#(
  parameter  int unsigned N_CLASS     = DEF_N_CLASS,
  parameter  int unsigned SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter  int unsigned H_OUT       = DEF_H_OUT,
  parameter  int unsigned W_OUT       = DEF_W_OUT,
  localparam int unsigned cls_w       = clog2_min1(N_CLASS),
  localparam int unsigned row_w       = clog2_min1(H_OUT),
  localparam int unsigned col_w       = clog2_min1(W_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_en,
  input  logic [SCORE_WIDTH-1:0] score_in,
  output logic [cls_w-1:0]       label_out,
  output logic [SCORE_WIDTH-1:0] max_score_out,
  output logic [row_w-1:0]       row_out,
  output logic [col_w-1:0]       col_out,
  output logic                   label_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t state, next_state;

  logic [cls_w-1:0]       cls_cnt;
  logic [row_w-1:0]       row_cnt;
  logic [col_w-1:0]       col_cnt;
  logic                   accept_c, last_cls_c, last_col_c, last_row_c;
  logic                   pix_done_c, frame_done_c, err_set_c;
  logic [SCORE_WIDTH-1:0] best_score_c;
  logic [cls_w-1:0]       best_idx_c;

  argmax_acc #(
    .SCORE_WIDTH (SCORE_WIDTH),
    .IDX_W       (cls_w)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .first        (cls_cnt == '0),
    .valid        (accept_c),
    .score        (score_in),
    .idx          (cls_cnt),
    .best_score_c (best_score_c),
    .best_idx_c   (best_idx_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (frame_done_c) next_state = FLUSH;
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Acceptance, pixel/frame completion and protocol-error decode.
  always_comb begin
    accept_c     = (state == RUN) && in_en;
    last_cls_c   = cls_cnt == cls_w'(N_CLASS - 1);
    last_col_c   = col_cnt == col_w'(W_OUT - 1);
    last_row_c   = row_cnt == row_w'(H_OUT - 1);
    pix_done_c   = accept_c && last_cls_c;
    frame_done_c = pix_done_c && last_col_c && last_row_c;
    err_set_c    = 1'b0;
    case (state)
      IDLE:    err_set_c = in_en;
      RUN:     err_set_c = start;
      FLUSH:   err_set_c = start || in_en;
      default: err_set_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cls_cnt       <= '0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      label_out     <= '0;
      max_score_out <= '0;
      row_out       <= '0;
      col_out       <= '0;
      label_valid   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      label_valid <= pix_done_c;
      done        <= frame_done_c;
      busy        <= next_state != IDLE;
      if (err_set_c) err <= 1'b1;

      if (state == IDLE && start) begin
        cls_cnt <= '0;
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (accept_c) begin
        if (last_cls_c) begin
          cls_cnt <= '0;
          if (last_col_c) begin
            col_cnt <= '0;
            row_cnt <= last_row_c ? '0 : row_cnt + row_w'(1);
          end else begin
            col_cnt <= col_cnt + col_w'(1);
          end
        end else begin
          cls_cnt <= cls_cnt + cls_w'(1);
        end
      end

      // Final compare result is captured together with the pixel position.
      if (pix_done_c) begin
        label_out     <= best_idx_c;
        max_score_out <= best_score_c;
        row_out       <= row_cnt;
        col_out       <= col_cnt;
      end
    end
  end

endmodule

// File: tb/tb_bcedn_argmax_out.sv
// Scoreboard bench for bcedn_argmax_out on a 4-class, 2x3-pixel configuration.
module tb_bcedn_argmax_out;

  localparam int unsigned NC   = 4;
  localparam int unsigned SW   = 30;
  localparam int unsigned H    = 2;
  localparam int unsigned W    = 3;
  localparam int unsigned NPIX = H * W;

  typedef logic signed [SW-1:0] sc_t;
  typedef struct {
    int  label;
    sc_t score;
    int  row;
    int  col;
    bit  last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_en = 1'b0;
  logic [SW-1:0] score_in = '0;
  logic [1:0]    label_out;
  logic [SW-1:0] max_score_out;
  logic [0:0]    row_out;
  logic [1:0]    col_out;
  logic          label_valid, busy, done, err;

  exp_t exp_q[$];
  sc_t  frame_s[NPIX][NC];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  bcedn_argmax_out #(
    .N_CLASS     (NC),
    .SCORE_WIDTH (SW),
    .H_OUT       (H),
    .W_OUT       (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_en         (in_en),
    .score_in      (score_in),
    .label_out     (label_out),
    .max_score_out (max_score_out),
    .row_out       (row_out),
    .col_out       (col_out),
    .label_valid   (label_valid),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference: the largest score, then the first class that reaches it.
  function automatic exp_t model(input int k);
    exp_t e;
    sc_t  mx;
    mx = frame_s[k][0];
    for (int c = 1; c < NC; c++) mx = (frame_s[k][c] > mx) ? frame_s[k][c] : mx;
    e.label = -1;
    for (int c = 0; c < NC; c++)
      if (e.label < 0 && frame_s[k][c] == mx) e.label = c;
    e.score = mx;
    e.row   = k / W;
    e.col   = k % W;
    e.last  = (k == NPIX - 1);
    return e;
  endfunction

  // Monitor: every label pulse must match the oldest expected pixel.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (label_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_label: got label %0d want no pulse", label_out);
        end else begin
          e = exp_q.pop_front();
          chk("label", longint'(label_out), longint'(e.label));
          chk("max_score", longint'($signed(max_score_out)), longint'(e.score));
          chk("row", longint'(row_out), longint'(e.row));
          chk("col", longint'(col_out), longint'(e.col));
          chk("done_with_label", longint'(done), longint'(e.last));
        end
      end else if (done) begin
        total++;
        bad++;
        $display("FAIL done_without_label: got done=1 want 0");
      end
      if (done) done_cnt++;
    end
  end

  task automatic cyc(input bit st, input bit en, input sc_t s);
    @(negedge clk);
    start    = st;
    in_en    = en;
    score_in = s;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_label"}, longint'(label_out), 0);
    chk({tag, "_score"}, longint'(max_score_out), 0);
    chk({tag, "_row"}, longint'(row_out), 0);
    chk({tag, "_col"}, longint'(col_out), 0);
    chk({tag, "_valid"}, longint'(label_valid), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_err"}, longint'(err), 0);
  endtask

  task automatic run_frame(input bit gapped, input bit start_mid, input bit en_with_start,
                           input bit en_in_flush);
    int   d0;
    exp_t last_e;
    d0 = done_cnt;
    cyc(1'b1, en_with_start, sc_t'(12345));
    for (int k = 0; k < NPIX; k++) begin
      exp_q.push_back(model(k));
      for (int c = 0; c < NC; c++) begin
        if (gapped)
          while ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b0, sc_t'($urandom));
        cyc(start_mid && k == 2 && c == 1, 1'b1, frame_s[k][c]);
        if (k == 0 && c == 0) chk("busy_in_run", longint'(busy), 1);
      end
    end
    cyc(1'b0, en_in_flush, sc_t'(-1));
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("labels_pending", longint'(exp_q.size()), 0);
    exp_q.delete();
    idle(1);
    chk("busy_after_done", longint'(busy), 0);
    chk("done_pulses", longint'(done_cnt - d0), 1);
    idle(3);
    last_e = model(NPIX - 1);
    chk("label_hold", longint'(label_out), longint'(last_e.label));
    chk("score_hold", longint'($signed(max_score_out)), longint'(last_e.score));
  endtask

  initial begin
    sc_t mn;
    mn = '0;
    mn[SW-1] = 1'b1;

    idle(2);
    check_zero("reset");
    rst = 1'b1;
    idle(2);

    // Mid-frame reset: two pixels complete, then abandon the third.
    for (int k = 0; k < NPIX; k++)
      for (int c = 0; c < NC; c++) frame_s[k][c] = sc_t'(int'($urandom_range(0, 200)) - 100);
    cyc(1'b1, 1'b0, '0);
    exp_q.push_back(model(0));
    exp_q.push_back(model(1));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, frame_s[i / NC][i % NC]);
    @(negedge clk);
    rst = 1'b0; in_en = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    chk("midreset_queue", longint'(exp_q.size()), 0);
    rst = 1'b1;
    idle(3);
    cyc(1'b0, 1'b1, sc_t'(77));
    idle(2);
    chk("err_in_idle", longint'(err), 1);
    do_reset();
    idle(1);
    chk("err_cleared", longint'(err), 0);

    // Directed: tie, all-negative with most-negative value, then peak at k mod NC.
    frame_s[0][0] = -5; frame_s[0][1] = 7;  frame_s[0][2] = 3;  frame_s[0][3] = 7;
    frame_s[1][0] = -9; frame_s[1][1] = -2; frame_s[1][2] = mn; frame_s[1][3] = -3;
    for (int k = 2; k < NPIX; k++) begin
      for (int c = 0; c < NC; c++) frame_s[k][c] = sc_t'(int'($urandom_range(0, 200)) - 100);
      frame_s[k][k % NC] = sc_t'(1000);
    end
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_directed", longint'(err), 0);

    // Random frame, played gap-free and then gapped.
    for (int k = 0; k < NPIX; k++)
      for (int c = 0; c < NC; c++)
        frame_s[k][c] = (k % 2 == 0) ? sc_t'(int'($urandom_range(0, 6)) - 3) : sc_t'($urandom);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("err_gapped", longint'(err), 0);

    // Protocol errors: each must set err while the frame still completes correctly.
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    chk("err_start_in_run", longint'(err), 1);
    do_reset();
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    chk("err_start_with_en", longint'(err), 1);
    do_reset();
    run_frame(1'b1, 1'b0, 1'b0, 1'b1);
    chk("err_en_in_flush", longint'(err), 1);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
